grid_scanner: RTL



---
 rtl/grid_scanner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/grid_scanner.sv
// rtl/grid_scanner.sv - frame-coherent 16x16 grid row scanner; popcount under GRID_SCANNER_POPCOUNT_EN
module grid_scanner #(
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][15:0] grid,
  input  logic              grid_valid,
  input  logic              scan_en,
  output logic [15:0]       row_sel,
  output logic [15:0]       col_data,
  output logic              frame_start,
  output logic              busy,
  output logic [8:0]        population,
  output logic              pop_valid
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] D_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_SHOW} state_t;

  state_t            state;
  logic [15:0][15:0] snap;
  logic              pending;
  logic [3:0]        row;
  logic [CW-1:0]     phase;
  logic [15:0][15:0] load_val;
  logic [3:0]        row_nxt;
  logic              show_end;

  // Value snap takes in LOAD: a deferred or coincident grid_valid captures grid.
  always_comb begin
    load_val = snap;
    if (pending || grid_valid) load_val = grid;
    row_nxt  = row + 4'd1;
    show_end = (state == S_SHOW) && (phase == D_LAST);
  end

  // Scan sequencer with outputs registered for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      snap        <= '0;
      pending     <= 1'b0;
      row         <= 4'd0;
      phase       <= '0;
      row_sel     <= 16'h0;
      col_data    <= 16'h0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (grid_valid && state != S_LOAD) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (scan_en) begin
            state       <= S_LOAD;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_LOAD: begin
          snap    <= load_val;
          pending <= 1'b0;
          row     <= 4'd0;
          phase   <= '0;
          if (HAS_BLANK) begin
            state <= S_BLANK;
          end else begin
            state    <= S_SHOW;
            row_sel  <= 16'h0001;
            col_data <= load_val[0];
          end
        end
        S_BLANK: begin
          if (phase == B_LAST) begin
            state    <= S_SHOW;
            phase    <= '0;
            row_sel  <= 16'h1 << row;
            col_data <= snap[row];
          end else begin
            phase <= phase + 1'b1;
          end
        end
        S_SHOW: begin
          if (show_end) begin
            phase    <= '0;
            row_sel  <= 16'h0;
            col_data <= 16'h0;
            if (!scan_en) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              row   <= 4'd0;
            end else if (row == 4'd15) begin
              state       <= S_LOAD;
              frame_start <= 1'b1;
            end else begin
              row <= row_nxt;
              if (HAS_BLANK) begin
                state <= S_BLANK;
              end else begin
                state    <= S_SHOW;
                row_sel  <= 16'h1 << row_nxt;
                col_data <= snap[row_nxt];
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GRID_SCANNER_POPCOUNT_EN
  logic [8:0] acc;
  logic [4:0] entry_pop;
  logic       entry_show;

  function automatic logic [4:0] pop16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Live cells of the row about to be shown, valid on the edge entering SHOW.
  always_comb begin
    entry_show = 1'b0;
    entry_pop  = 5'd0;
    if (state == S_LOAD && !HAS_BLANK) begin
      entry_show = 1'b1;
      entry_pop  = pop16(load_val[0]);
    end else if (state == S_BLANK && phase == B_LAST) begin
      entry_show = 1'b1;
      entry_pop  = pop16(snap[row]);
    end else if (show_end && scan_en && row != 4'd15 && !HAS_BLANK) begin
      entry_show = 1'b1;
      entry_pop  = pop16(snap[row_nxt]);
    end
  end

  // Per-frame accumulator; published only when row 15 finishes its dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= 9'd0;
      population <= 9'd0;
      pop_valid  <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      if (state == S_LOAD) acc <= entry_show ? 9'(entry_pop) : 9'd0;
      else if (entry_show) acc <= acc + 9'(entry_pop);
      if (show_end && row == 4'd15) begin
        population <= acc;
        pop_valid  <= 1'b1;
      end
    end
  end
`else
  assign population = 9'd0;
  assign pop_valid  = 1'b0;
`endif

endmodule
